sm_l2_src_remap: RTL

//  Sits directly downstream of the SM L1-cache arbiter, between it and the L2/NoC port.

---
 rtl/sm_l2_src_remap.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sm_l2_src_remap.sv
// SM->L2 source remapper: swaps the wide {cache-id, A_SOURCE} for a free-list index and restores it on the response.
// Optional SM_L2_REMAP_REQ_REG_EN adds a 1-entry registered slice on the request path.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DCACHE_BLOCKWORDS
`define DCACHE_BLOCKWORDS 2
`endif
`ifndef BYTESOFWORD
`define BYTESOFWORD 4
`endif
`ifndef D_SOURCE
`define D_SOURCE 8
`endif

module sm_l2_src_remap #(
  parameter int NUM_ENTRY   = 8,
  parameter int ENTRY_DEPTH = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       req_in_valid_i,
  output logic                                       req_in_ready_o,
  input  logic [2:0]                                 req_in_a_opcode_i,
  input  logic [2:0]                                 req_in_a_param_i,
  input  logic [`XLEN-1:0]                           req_in_a_addr_i,
  input  logic [`DCACHE_BLOCKWORDS*`XLEN-1:0]        req_in_a_data_i,
  input  logic [`DCACHE_BLOCKWORDS*`BYTESOFWORD-1:0] req_in_a_mask_i,
  input  logic [`D_SOURCE-1:0]                       req_in_a_source_i,
  output logic                                       req_out_valid_o,
  input  logic                                       req_out_ready_i,
  output logic [2:0]                                 req_out_a_opcode_o,
  output logic [2:0]                                 req_out_a_param_o,
  output logic [`XLEN-1:0]                           req_out_a_addr_o,
  output logic [`DCACHE_BLOCKWORDS*`XLEN-1:0]        req_out_a_data_o,
  output logic [`DCACHE_BLOCKWORDS*`BYTESOFWORD-1:0] req_out_a_mask_o,
  output logic [ENTRY_DEPTH-1:0]                     req_out_a_source_o,
  input  logic                                       rsp_in_valid_i,
  output logic                                       rsp_in_ready_o,
  input  logic [2:0]                                 rsp_in_d_opcode_i,
  input  logic [`XLEN-1:0]                           rsp_in_d_addr_i,
  input  logic [`DCACHE_BLOCKWORDS*`XLEN-1:0]        rsp_in_d_data_i,
  input  logic [ENTRY_DEPTH-1:0]                     rsp_in_d_source_i,
  output logic                                       rsp_out_valid_o,
  input  logic                                       rsp_out_ready_i,
  output logic [2:0]                                 rsp_out_d_opcode_o,
  output logic [`XLEN-1:0]                           rsp_out_d_addr_o,
  output logic [`DCACHE_BLOCKWORDS*`XLEN-1:0]        rsp_out_d_data_o,
  output logic [`D_SOURCE-1:0]                       rsp_out_d_source_o,
  output logic [ENTRY_DEPTH:0]                       outstanding_cnt_o,
  output logic                                       err_unalloc_o
);

  localparam int DW = `DCACHE_BLOCKWORDS * `XLEN;
  localparam int MW = `DCACHE_BLOCKWORDS * `BYTESOFWORD;
  localparam int SW = `D_SOURCE;
  localparam int CW = ENTRY_DEPTH + 1;

  function automatic logic [ENTRY_DEPTH-1:0] lowest_set(input logic [NUM_ENTRY-1:0] v);
    lowest_set = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ENTRY_DEPTH'(i);
    end
  endfunction

  logic [NUM_ENTRY-1:0] free_q;
  logic [NUM_ENTRY-1:0] free_d;
  logic [ENTRY_DEPTH-1:0] alloc_idx;
  logic                 full;
  logic                 alloc_fire;
  logic                 rsp_fire;
  logic                 hit_free;
  logic [CW-1:0]        cnt_q;
  logic                 err_q;
  logic [SW-1:0]        src_tab [NUM_ENTRY];

  assign alloc_idx = lowest_set(free_q);
  assign full      = ~|free_q;

`ifdef SM_L2_REMAP_REQ_REG_EN
  logic                   vld_p1;
  logic [2:0]             opcode_p1;
  logic [2:0]             param_p1;
  logic [`XLEN-1:0]       addr_p1;
  logic [DW-1:0]          data_p1;
  logic [MW-1:0]          mask_p1;
  logic [ENTRY_DEPTH-1:0] source_p1;

  // Allocation happens on entry into the slice, so the index travels with the beat.
  assign req_in_ready_o = ~full & (~vld_p1 | req_out_ready_i);
  assign alloc_fire     = req_in_valid_i & req_in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (alloc_fire) begin
      vld_p1 <= 1'b1;
    end else if (req_out_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      opcode_p1 <= req_in_a_opcode_i;
      param_p1  <= req_in_a_param_i;
      addr_p1   <= req_in_a_addr_i;
      data_p1   <= req_in_a_data_i;
      mask_p1   <= req_in_a_mask_i;
      source_p1 <= alloc_idx;
    end
  end

  assign req_out_valid_o    = vld_p1;
  assign req_out_a_opcode_o = opcode_p1;
  assign req_out_a_param_o  = param_p1;
  assign req_out_a_addr_o   = addr_p1;
  assign req_out_a_data_o   = data_p1;
  assign req_out_a_mask_o   = mask_p1;
  assign req_out_a_source_o = source_p1;
`else
  assign req_out_valid_o    = req_in_valid_i & ~full;
  assign req_in_ready_o     = req_out_ready_i & ~full;
  assign alloc_fire         = req_out_valid_o & req_out_ready_i;
  assign req_out_a_opcode_o = req_in_a_opcode_i;
  assign req_out_a_param_o  = req_in_a_param_i;
  assign req_out_a_addr_o   = req_in_a_addr_i;
  assign req_out_a_data_o   = req_in_a_data_i;
  assign req_out_a_mask_o   = req_in_a_mask_i;
  assign req_out_a_source_o = alloc_idx;
`endif

  always_ff @(posedge clk) begin
    if (alloc_fire) src_tab[alloc_idx] <= req_in_a_source_i;
  end

  logic                 vld_p0;
  logic [2:0]           rsp_opcode_p0;
  logic [`XLEN-1:0]     rsp_addr_p0;
  logic [DW-1:0]        rsp_data_p0;
  logic [SW-1:0]        rsp_source_p0;

  assign rsp_in_ready_o = ~vld_p0 | rsp_out_ready_i;
  assign rsp_fire       = rsp_in_valid_i & rsp_in_ready_o;
  assign hit_free       = free_q[rsp_in_d_source_i];

  // Release before claim: a stray response can never steal an index allocated in the same edge.
  always_comb begin
    free_d = free_q;
    if (rsp_fire)   free_d[rsp_in_d_source_i] = 1'b1;
    if (alloc_fire) free_d[alloc_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q  <= '1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      free_q <= free_d;
      case ({alloc_fire, rsp_fire & ~hit_free})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (rsp_fire & hit_free) err_q <= 1'b1;
      if (rsp_fire) begin
        vld_p0 <= 1'b1;
      end else if (rsp_out_ready_i) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  // Response stage boundary: beat plus restored source registered together.
  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      rsp_opcode_p0 <= rsp_in_d_opcode_i;
      rsp_addr_p0   <= rsp_in_d_addr_i;
      rsp_data_p0   <= rsp_in_d_data_i;
      rsp_source_p0 <= src_tab[rsp_in_d_source_i];
    end
  end

  assign rsp_out_valid_o    = vld_p0;
  assign rsp_out_d_opcode_o = rsp_opcode_p0;
  assign rsp_out_d_addr_o   = rsp_addr_p0;
  assign rsp_out_d_data_o   = rsp_data_p0;
  assign rsp_out_d_source_o = rsp_source_p0;
  assign outstanding_cnt_o  = cnt_q;
  assign err_unalloc_o      = err_q;

endmodule
